// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32 funct3 width codes for loads and stores
//   - FSM state encoding for mem_lsu
//   - Width of the byte offset within a 32-bit word
//   - lsu_legal(): decides whether a request may touch memory
package mem_lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam int LSU_OFF_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCESS    = 2'd1,
        ST_LOAD_WAIT = 2'd2
    } lsu_state_e;

    // Unsigned widths exist only for loads, halfwords need even addresses,
    // words need word-aligned addresses; every other funct3 is rejected.
    function automatic logic lsu_legal(input logic                 we,
                                       input logic [2:0]           funct3,
                                       input logic [LSU_OFF_W-1:0] off);
        logic ok;
        case (funct3)
            LSU_B:   ok = 1'b1;
            LSU_H:   ok = ~off[0];
            LSU_W:   ok = (off == 2'b00);
            LSU_BU:  ok = ~we;
            LSU_HU:  ok = ~we & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Load data alignment: selects the addressed byte/halfword from a 32-bit
// memory word and sign- or zero-extends it according to funct3.
// Purely combinational so it can also sit behind a cache data path.
//   mem_rdata  in   32  raw memory word
//   offset     in   2   byte offset of the access within the word
//   funct3     in   3   RV32 load width code
//   ext        out  32  aligned, extended load result
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0]          mem_rdata,
    input  logic [LSU_OFF_W-1:0] offset,
    input  logic [2:0]           funct3,
    output logic [31:0]          ext
);

    logic signed [7:0]  sel_b;
    logic signed [15:0] sel_h;

    always_comb begin
        case (offset)
            2'd0:    sel_b = mem_rdata[7:0];
            2'd1:    sel_b = mem_rdata[15:8];
            2'd2:    sel_b = mem_rdata[23:16];
            default: sel_b = mem_rdata[31:24];
        endcase
    end

    // Halfword accesses are always even, so only offset[1] picks the half.
    assign sel_h = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (funct3)
            LSU_B:   ext = 32'(sel_b);
            LSU_BU:  ext = {24'd0, sel_b};
            LSU_H:   ext = 32'(sel_h);
            LSU_HU:  ext = {16'd0, sel_h};
            default: ext = mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for a single-port, word-organised memory with
// one-cycle read latency. Accepts one RV32 load/store at a time.
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   req_*          request from execute: valid/ready, we, funct3, addr, wdata
//   rsp_*          one-cycle completion pulse with load data and error flag
//   mem_*          memory side: word address, read strobe, byte write mask,
//                  lane-replicated write data, read data (1 cycle after strobe)
// Latency accept->response: error 1, store 2, load 3 cycles.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rstrb_o,
    input  logic [31:0]           mem_rdata_i,
    output logic [3:0]            mem_wmask_o,
    output logic [31:0]           mem_wdata_o
);

    lsu_state_e           state;
    logic                 is_store_p1;
    logic [2:0]           funct3_p1;
    logic [LSU_OFF_W-1:0] off_p1;
    logic                 accept;
    logic                 legal;
    logic [31:0]          load_ext;

    function automatic logic [3:0] store_mask(input logic [2:0]           funct3,
                                              input logic [LSU_OFF_W-1:0] off);
        logic [3:0] m;
        case (funct3)
            LSU_B:   m = 4'b0001 << off;
            LSU_H:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicate the LSB-justified store data across all lanes; the mask
    // selects which lanes the memory actually writes.
    function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                               input logic [31:0] d);
        logic [31:0] r;
        case (funct3)
            LSU_B:   r = {4{d[7:0]}};
            LSU_H:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    assign req_ready_o = (state == ST_IDLE);
    assign accept      = req_valid_i & req_ready_o;
    assign legal       = lsu_legal(req_we_i, req_funct3_i, req_addr_i[LSU_OFF_W-1:0]);

    mem_lsu_align u_align (
        .mem_rdata (mem_rdata_i),
        .offset    (off_p1),
        .funct3    (funct3_p1),
        .ext       (load_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            is_store_p1 <= 1'b0;
            funct3_p1   <= 3'd0;
            off_p1      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_rstrb_o <= 1'b0;
            mem_wmask_o <= 4'd0;
            mem_wdata_o <= 32'd0;
        end else begin
            // Pulses: strobe, mask and response are high for one cycle only.
            rsp_valid_o <= 1'b0;
            mem_rstrb_o <= 1'b0;
            mem_wmask_o <= 4'd0;

            case (state)
                // Stage boundary: request capture -> memory access
                ST_IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            mem_addr_o  <= {req_addr_i[ADDR_WIDTH-1:LSU_OFF_W], {LSU_OFF_W{1'b0}}};
                            is_store_p1 <= req_we_i;
                            funct3_p1   <= req_funct3_i;
                            off_p1      <= req_addr_i[LSU_OFF_W-1:0];
                            if (req_we_i) begin
                                mem_wmask_o <= store_mask(req_funct3_i, req_addr_i[LSU_OFF_W-1:0]);
                                mem_wdata_o <= store_data(req_funct3_i, req_wdata_i);
                            end else begin
                                mem_rstrb_o <= 1'b1;
                            end
                            state <= ST_ACCESS;
                        end else begin
                            // Rejected without touching memory.
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= 32'd0;
                        end
                    end
                end

                // Stage boundary: memory access -> store completion / load wait
                ST_ACCESS: begin
                    if (is_store_p1) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= 32'd0;
                        state       <= ST_IDLE;
                    end else begin
                        state <= ST_LOAD_WAIT;
                    end
                end

                // Stage boundary: read data return -> load response
                ST_LOAD_WAIT: begin
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= load_ext;
                    state       <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a small byte-writable memory model.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'd0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic        mem_rstrb_o;
    logic [31:0] mem_rdata_i;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_wdata_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_lsu #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rstrb_o  (mem_rstrb_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_wmask_o  (mem_wmask_o),
        .mem_wdata_o  (mem_wdata_o)
    );

    always #5 clk = ~clk;

    // Memory model: 16 words, byte-masked writes, read data one cycle after strobe.
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
            mem_rdata_i <= 32'd0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask_o[b]) mem[mem_addr_o[5:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            if (mem_rstrb_o) mem_rdata_i <= mem[mem_addr_o[5:2]];
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } rec_t;

    rec_t vec[$];

    function automatic rec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input logic [31:0] ea,
                                input logic [3:0] em, input logic [31:0] ew, input logic [31:0] er);
        rec_t r;
        r.we = we; r.f3 = f3; r.addr = addr; r.wdata = wdata; r.err = err;
        r.exp_addr = ea; r.exp_wmask = em; r.exp_wdata = ew; r.exp_rdata = er;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic run_req(input rec_t r);
        int lat;
        lat = r.err ? 1 : (r.we ? 2 : 3);
        @(negedge clk);
        chk("req_ready", 32'(req_ready_o), 32'd1);
        req_valid_i  = 1'b1;
        req_we_i     = r.we;
        req_funct3_i = r.f3;
        req_addr_i   = r.addr;
        req_wdata_i  = r.wdata;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k == 1 && !r.err) begin
                chk("mem_addr", mem_addr_o, r.exp_addr);
                chk("mem_rstrb", 32'(mem_rstrb_o), 32'(!r.we));
                chk("mem_wmask", 32'(mem_wmask_o), 32'(r.exp_wmask));
                if (r.we) chk("mem_wdata", mem_wdata_o, r.exp_wdata);
            end else begin
                chk("strobe_clear", {27'd0, mem_rstrb_o, mem_wmask_o}, 32'd0);
            end
            if (k < lat) begin
                chk("rsp_early", 32'(rsp_valid_o), 32'd0);
            end else begin
                chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
                chk("rsp_err", 32'(rsp_err_o), 32'(r.err));
                chk("rsp_rdata", rsp_rdata_o, r.exp_rdata);
            end
        end
    endtask

    initial begin
        //            we    f3      addr    wdata      err   eaddr   mask     ewdata      erdata
        vec.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0));
        vec.push_back(mk(1, 3'b000, 32'h13, 32'h000000A5, 0, 32'h10, 4'b1000, 32'hA5A5A5A5, 32'h0));
        vec.push_back(mk(0, 3'b010, 32'h10, 32'h0,        0, 32'h10, 4'b0000, 32'h0, 32'hA5ADBEEF));
        vec.push_back(mk(0, 3'b000, 32'h13, 32'h0,        0, 32'h10, 4'b0000, 32'h0, 32'hFFFFFFA5));
        vec.push_back(mk(0, 3'b100, 32'h13, 32'h0,        0, 32'h10, 4'b0000, 32'h0, 32'h000000A5));
        vec.push_back(mk(0, 3'b001, 32'h12, 32'h0,        0, 32'h10, 4'b0000, 32'h0, 32'hFFFFA5AD));
        vec.push_back(mk(0, 3'b101, 32'h12, 32'h0,        0, 32'h10, 4'b0000, 32'h0, 32'h0000A5AD));
        vec.push_back(mk(0, 3'b000, 32'h10, 32'h0,        0, 32'h10, 4'b0000, 32'h0, 32'hFFFFFFEF));
        vec.push_back(mk(0, 3'b010, 32'h11, 32'h0,        1, 32'h0,  4'b0000, 32'h0, 32'h0));
        vec.push_back(mk(1, 3'b001, 32'h13, 32'h1234,     1, 32'h0,  4'b0000, 32'h0, 32'h0));
        vec.push_back(mk(0, 3'b011, 32'h10, 32'h0,        1, 32'h0,  4'b0000, 32'h0, 32'h0));
        vec.push_back(mk(0, 3'b111, 32'h10, 32'h0,        1, 32'h0,  4'b0000, 32'h0, 32'h0));
        vec.push_back(mk(0, 3'b101, 32'h11, 32'h0,        1, 32'h0,  4'b0000, 32'h0, 32'h0));
        vec.push_back(mk(1, 3'b100, 32'h14, 32'h0,        1, 32'h0,  4'b0000, 32'h0, 32'h0));
        vec.push_back(mk(1, 3'b001, 32'h16, 32'h00001234, 0, 32'h14, 4'b1100, 32'h12341234, 32'h0));
        vec.push_back(mk(1, 3'b000, 32'h14, 32'hFFFFFF80, 0, 32'h14, 4'b0001, 32'h80808080, 32'h0));
        vec.push_back(mk(0, 3'b101, 32'h16, 32'h0,        0, 32'h14, 4'b0000, 32'h0, 32'h00001234));
        vec.push_back(mk(0, 3'b000, 32'h14, 32'h0,        0, 32'h14, 4'b0000, 32'h0, 32'hFFFFFF80));
        vec.push_back(mk(0, 3'b100, 32'h14, 32'h0,        0, 32'h14, 4'b0000, 32'h0, 32'h00000080));
        vec.push_back(mk(0, 3'b001, 32'h14, 32'h0,        0, 32'h14, 4'b0000, 32'h0, 32'h00000080));

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp", {29'd0, rsp_valid_o, rsp_err_o, mem_rstrb_o}, 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wmask", 32'(mem_wmask_o), 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("post_rst_ready", 32'(req_ready_o), 32'd1);

        foreach (vec[i]) run_req(vec[i]);

        // Back-to-back: store issued in the cycle the load response is high
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
        req_addr_i = 32'h10; req_wdata_i = 32'h0;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("b2b_no_rsp", 32'(rsp_valid_o), 32'd0);
        @(posedge clk); #1;
        chk("b2b_ld_valid", 32'(rsp_valid_o), 32'd1);
        chk("b2b_ld_rdata", rsp_rdata_o, 32'hA5ADBEEF);
        chk("b2b_ready", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
        req_addr_i = 32'h18; req_wdata_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk("b2b_pulse_end", 32'(rsp_valid_o), 32'd0);
        chk("b2b_st_mask", 32'(mem_wmask_o), 32'hF);
        chk("b2b_st_addr", mem_addr_o, 32'h18);
        chk("b2b_st_wdata", mem_wdata_o, 32'hCAFEF00D);
        @(posedge clk); #1;
        chk("b2b_st_valid", 32'(rsp_valid_o), 32'd1);
        chk("b2b_st_err", 32'(rsp_err_o), 32'd0);
        run_req(mk(0, 3'b010, 32'h18, 32'h0, 0, 32'h18, 4'b0000, 32'h0, 32'hCAFEF00D));

        // Asynchronous reset during LOAD_WAIT of LB 0x13
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b000;
        req_addr_i = 32'h13; req_wdata_i = 32'h0;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("mid_addr", mem_addr_o, 32'h10);
        #2 rst = 1'b1;
        #1;
        chk("arst_addr", mem_addr_o, 32'd0);
        chk("arst_rdata", rsp_rdata_o, 32'd0);
        chk("arst_ctl", {25'd0, rsp_valid_o, rsp_err_o, mem_rstrb_o, mem_wmask_o}, 32'd0);
        chk("arst_wdata", mem_wdata_o, 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("arst_no_rsp", 32'(rsp_valid_o), 32'd0);
            chk("arst_ready", 32'(req_ready_o), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
